pio_poll_reader: RTL



---
 rtl/pio_poll_pkg.sv | 20 ++
 rtl/pio_poll_timer.sv | 43 ++++
 rtl/pio_poll_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO poll reader.
//   state_t       : poll FSM states (IDLE, READ, WAIT)
//   PIO_DATA_ADDR : word address of the PIO data register
//   cnt_w()       : bit width needed for a down-counter with n distinct values
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // A counter covering 0..n-1 needs clog2(n) bits; never fewer than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// Reloadable down-counter with a terminal-count flag.
//   clk, reset_n : clock, asynchronous active-low reset (count -> RESET_VAL)
//   load         : load load_val this cycle (has priority over dec)
//   load_val     : reload value
//   dec          : decrement by one this cycle; saturates at zero
//   tc           : high while the count is zero
module pio_poll_timer
    import pio_poll_pkg::*;
#(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/pio_poll_reader.sv
// Avalon-MM initiator that periodically reads an input PIO and publishes
// changed values on a valid/ready stream.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : polling allowed when high
//   avm_address    : responder word address (constant PIO_ADDR)
//   avm_read       : one-cycle read strobe per poll
//   avm_readdata   : responder data; only [DATA_W-1:0] is used
//   out_data       : last published value
//   out_valid      : out_data holds an unconsumed value
//   out_ready      : consumer accepts when out_valid && out_ready
//   overrun        : sticky, an unconsumed value was overwritten
//   clear_overrun  : synchronous clear of overrun (a coincident set wins)
//   busy           : high in READ and WAIT
module pio_poll_reader
    import pio_poll_pkg::*;
#(
    parameter int         POLL_CYCLES  = 16,
    parameter int         READ_LATENCY = 1,
    parameter int         DATA_W       = 8,
    parameter logic [1:0] PIO_ADDR     = PIO_DATA_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              clear_overrun,
    output logic              busy
);

    localparam int PW = cnt_w(POLL_CYCLES);
    localparam int LW = cnt_w(READ_LATENCY);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);
    localparam logic [LW-1:0] LAT_RELOAD  = LW'(READ_LATENCY - 1);

    state_t            state_q,     state_d;
    logic              avm_read_q,  avm_read_d;
    logic              busy_q,      busy_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q,   overrun_d;
    logic [DATA_W-1:0] last_q,      last_d;
    logic              primed_q,    primed_d;

    logic              poll_load, poll_dec, poll_tc;
    logic              lat_load,  lat_dec,  lat_tc;
    logic              sample_fire, publish;
    logic [DATA_W-1:0] sample;

    // Poll interval: counts only in IDLE with enable high; held at its
    // reload value otherwise, so every IDLE entry starts a full interval.
    assign poll_load = (state_q != IDLE) || !enable;
    assign poll_dec  = (state_q == IDLE) && enable;

    pio_poll_timer #(
        .W         (PW),
        .RESET_VAL (POLL_RELOAD)
    ) u_poll_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (poll_load),
        .load_val (POLL_RELOAD),
        .dec      (poll_dec),
        .tc       (poll_tc)
    );

    // Read latency: loaded in READ so WAIT ends READ_LATENCY cycles later.
    assign lat_load = (state_q == READ);
    assign lat_dec  = (state_q == WAIT);

    pio_poll_timer #(
        .W         (LW),
        .RESET_VAL (LAT_RELOAD)
    ) u_lat_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lat_load),
        .load_val (LAT_RELOAD),
        .dec      (lat_dec),
        .tc       (lat_tc)
    );

    assign sample      = avm_readdata[DATA_W-1:0];
    assign sample_fire = (state_q == WAIT) && lat_tc;
    assign publish     = sample_fire && (!primed_q || (sample != last_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && poll_tc) state_d = READ;
            READ:    state_d = WAIT;
            WAIT:    if (lat_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        avm_read_d = (state_d == READ);
        busy_d     = (state_d != IDLE);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        last_d      = last_q;
        primed_d    = primed_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (sample_fire) begin
            last_d   = sample;
            primed_d = 1'b1;
        end
        // A publish overrides the accept and the clear issued above.
        if (publish) begin
            out_data_d  = sample;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            avm_read_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            last_q      <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            avm_read_q  <= avm_read_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            last_q      <= last_d;
            primed_q    <= primed_d;
        end
    end

    assign avm_address = PIO_ADDR;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;

    generate
        if (DATA_W < 32) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^avm_readdata[31:DATA_W];
        end
    endgenerate

endmodule
